// File: rtl/sr_load_sched.sv
// Round-robin scheduler sharing one serial-in shift register between two requesters.
// The granted word is cleared into the register, then shifted in MSB-first, one bit per DIV-clock tick.
module sr_load_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 134217728
) (
  input  logic             CLK,
  input  logic             R_N,
  input  logic             REQ_A,
  input  logic [WIDTH-1:0] DATA_A,
  output logic             ACK_A,
  input  logic             REQ_B,
  input  logic [WIDTH-1:0] DATA_B,
  output logic             ACK_B,
  output logic             SR_R,
  output logic             SR_CE,
  output logic             SR_SLI,
  output logic             BUSY,
  output logic             DONE,
  output logic             DONE_ID
);

  localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W  = $clog2(WIDTH + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [WIDTH-1:0]  word_reg, word_next;
  logic              last_b_reg, last_b_next;
  logic              id_reg, id_next;
  logic              ack_a_reg, ack_a_next;
  logic              ack_b_reg, ack_b_next;
  logic              sr_r_reg, sr_r_next;
  logic              sr_ce_reg, sr_ce_next;
  logic              sr_sli_reg, sr_sli_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              done_id_reg, done_id_next;

  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    bit_next     = bit_reg;
    word_next    = word_reg;
    last_b_next  = last_b_reg;
    id_next      = id_reg;
    ack_a_next   = 1'b0;
    ack_b_next   = 1'b0;
    sr_r_next    = 1'b0;
    sr_ce_next   = 1'b0;
    sr_sli_next  = 1'b0;
    done_next    = 1'b0;
    done_id_next = done_id_reg;
    // BUSY trails the state by one cycle, so the ACK cycle itself reads as not busy
    busy_next    = (state_reg != S_IDLE);

    unique case (state_reg)
      S_IDLE: begin
        if (REQ_A || REQ_B) begin
          // B wins only when A is absent or A was the one served last
          if (REQ_B && (!REQ_A || !last_b_reg)) begin
            ack_b_next  = 1'b1;
            word_next   = DATA_B;
            id_next     = 1'b1;
            last_b_next = 1'b1;
          end else begin
            ack_a_next  = 1'b1;
            word_next   = DATA_A;
            id_next     = 1'b0;
            last_b_next = 1'b0;
          end
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        sr_r_next  = 1'b1;
        tick_next  = '0;
        bit_next   = '0;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (tick_reg == TICK_LAST) begin
          tick_next   = '0;
          sr_ce_next  = 1'b1;
          sr_sli_next = word_reg[WIDTH-1];
          word_next   = word_reg << 1;
          bit_next    = bit_reg + BIT_W'(1);
          if (bit_reg == BIT_LAST) begin
            state_next = S_DONE;
          end
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end
      S_DONE: begin
        done_next    = 1'b1;
        done_id_next = id_reg;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      state_reg   <= S_IDLE;
      tick_reg    <= '0;
      bit_reg     <= '0;
      word_reg    <= '0;
      last_b_reg  <= 1'b1;
      id_reg      <= 1'b0;
      ack_a_reg   <= 1'b0;
      ack_b_reg   <= 1'b0;
      sr_r_reg    <= 1'b0;
      sr_ce_reg   <= 1'b0;
      sr_sli_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      done_id_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      bit_reg     <= bit_next;
      word_reg    <= word_next;
      last_b_reg  <= last_b_next;
      id_reg      <= id_next;
      ack_a_reg   <= ack_a_next;
      ack_b_reg   <= ack_b_next;
      sr_r_reg    <= sr_r_next;
      sr_ce_reg   <= sr_ce_next;
      sr_sli_reg  <= sr_sli_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      done_id_reg <= done_id_next;
    end
  end

  assign ACK_A   = ack_a_reg;
  assign ACK_B   = ack_b_reg;
  assign SR_R    = sr_r_reg;
  assign SR_CE   = sr_ce_reg;
  assign SR_SLI  = sr_sli_reg;
  assign BUSY    = busy_reg;
  assign DONE    = done_reg;
  assign DONE_ID = done_id_reg;

endmodule

// File: tb/tb_sr_load_sched.sv
// Bench for sr_load_sched: instance 0 runs DIV=3, instance 1 runs DIV=1.
// Expected loads {id, word} are queued at stimulus time and checked against a downstream register model on DONE.
module tb_sr_load_sched;

  localparam int W = 4;

  logic CLK = 1'b0;
  logic R_N = 1'b0;
  always #5 CLK = ~CLK;

  logic         req_a [2];
  logic         req_b [2];
  logic [W-1:0] data_a [2];
  logic [W-1:0] data_b [2];
  logic [1:0]   ack_a, ack_b, sr_r, sr_ce, sr_sli, busy, done, done_id;

  logic [W:0] sb [2][$];
  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int DV = (gi == 0) ? 3 : 1;

    sr_load_sched #(.WIDTH(W), .DIV(DV)) u_dut (
      .CLK    (CLK),
      .R_N    (R_N),
      .REQ_A  (req_a[gi]),
      .DATA_A (data_a[gi]),
      .ACK_A  (ack_a[gi]),
      .REQ_B  (req_b[gi]),
      .DATA_B (data_b[gi]),
      .ACK_B  (ack_b[gi]),
      .SR_R   (sr_r[gi]),
      .SR_CE  (sr_ce[gi]),
      .SR_SLI (sr_sli[gi]),
      .BUSY   (busy[gi]),
      .DONE   (done[gi]),
      .DONE_ID(done_id[gi])
    );

    logic         inflight  = 1'b0;
    logic         post_done = 1'b0;
    int           t_ack     = 0;
    int           k         = 0;
    int           busy_cnt  = 0;
    logic [W-1:0] q         = '0;

    always @(negedge CLK) begin
      if (!R_N) begin
        inflight  <= 1'b0;
        post_done <= 1'b0;
      end else begin
        if (sr_r[gi]) q <= '0;
        else if (sr_ce[gi]) q <= {q[W-2:0], sr_sli[gi]};
        if (inflight && busy[gi]) busy_cnt <= busy_cnt + 1;
        if (post_done) check_val("busy_after_done", int'(busy[gi]), 0);
        post_done <= done[gi];

        if (ack_a[gi] || ack_b[gi]) begin
          check_val("ack_both", int'(ack_a[gi] & ack_b[gi]), 0);
          check_val("ack_while_busy", int'(busy[gi]), 0);
          check_val("ack_expected", int'(sb[gi].size() > 0), 1);
          if (sb[gi].size() > 0) check_val("grant_id", int'(ack_b[gi]), int'(sb[gi][0][W]));
          inflight <= 1'b1;
          t_ack    <= cyc;
          k        <= 0;
          busy_cnt <= 0;
        end

        if (inflight) begin
          if (sr_r[gi]) check_val("sr_r_cycle", cyc - t_ack, 1);
          if (sr_ce[gi]) begin
            check_val("r_ce_overlap", int'(sr_r[gi]), 0);
            check_val("ce_cycle", cyc - t_ack, 1 + (k + 1) * DV);
            k <= k + 1;
          end
        end

        if (done[gi]) begin
          check_val("done_in_load", int'(inflight), 1);
          if (inflight && sb[gi].size() > 0) begin
            check_val("done_cycle", cyc - t_ack, 2 + W * DV);
            check_val("ce_count", k, W);
            check_val("busy_len", busy_cnt + int'(busy[gi]), 2 + W * DV);
            check_val("sr_word", int'(q), int'(sb[gi][0][W-1:0]));
            check_val("done_id", int'(done_id[gi]), int'(sb[gi][0][W]));
            void'(sb[gi].pop_front());
          end
          inflight <= 1'b0;
        end
      end
    end
  end

  task automatic drv();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_ack(input int inst, output int t, output int id);
    int got;
    got = 0;
    t   = -1;
    id  = -1;
    for (int n = 0; n < 300 && got == 0; n++) begin
      @(negedge CLK);
      if (ack_a[inst] || ack_b[inst]) begin
        got = 1;
        t   = cyc;
        id  = int'(ack_b[inst]);
      end
    end
    check_val("ack_seen", got, 1);
  endtask

  task automatic wait_drain(input int inst);
    for (int n = 0; n < 300 && sb[inst].size() != 0; n++) @(negedge CLK);
    @(negedge CLK);
    check_val("drain", sb[inst].size(), 0);
  endtask

  initial begin
    int t, t_prev, id;
    for (int i = 0; i < 2; i++) begin
      req_a[i]  = 1'b0;
      req_b[i]  = 1'b0;
      data_a[i] = '0;
      data_b[i] = '0;
    end

    // Reset, then idle with no requests
    repeat (3) drv();
    R_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check_val("idle_outs", int'({ack_a, ack_b, sr_r, sr_ce, sr_sli, busy, done, done_id}), 0);
    end

    // Single load from A
    sb[0].push_back({1'b0, 4'b1011});
    drv();
    req_a[0]  = 1'b1;
    data_a[0] = 4'b1011;
    wait_ack(0, t, id);
    check_val("single_id", id, 0);
    drv();
    req_a[0] = 1'b0;
    wait_drain(0);

    // Both held from reset: strict alternation starting with A
    drv();
    R_N = 1'b0;
    drv();
    R_N = 1'b1;
    for (int i = 0; i < 4; i++) sb[0].push_back((i % 2 == 0) ? {1'b0, 4'h5} : {1'b1, 4'hC});
    drv();
    req_a[0]  = 1'b1;
    req_b[0]  = 1'b1;
    data_a[0] = 4'h5;
    data_b[0] = 4'hC;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, t, id);
      check_val("rr_id", id, i % 2);
      if (i > 0) check_val("rr_gap", t - t_prev, 15);
      t_prev = t;
    end
    drv();
    req_a[0] = 1'b0;
    req_b[0] = 1'b0;
    wait_drain(0);

    // B raised mid-load waits for the first IDLE cycle
    sb[0].push_back({1'b0, 4'h9});
    sb[0].push_back({1'b1, 4'h6});
    drv();
    req_a[0]  = 1'b1;
    data_a[0] = 4'h9;
    wait_ack(0, t_prev, id);
    drv();
    req_a[0] = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    req_b[0]  = 1'b1;
    data_b[0] = 4'h6;
    wait_ack(0, t, id);
    check_val("late_b_id", id, 1);
    check_val("late_b_gap", t - t_prev, 15);
    drv();
    req_b[0] = 1'b0;
    wait_drain(0);

    // Reset in the middle of a load abandons it
    sb[0].push_back({1'b0, 4'h3});
    drv();
    req_a[0]  = 1'b1;
    data_a[0] = 4'h3;
    wait_ack(0, t, id);
    drv();
    req_a[0] = 1'b0;
    repeat (7) @(posedge CLK);
    #2;
    check_val("busy_before_rst", int'(busy[0]), 1);
    R_N = 1'b0;
    #1;
    check_val("rst_async_outs", int'({ack_a[0], ack_b[0], sr_r[0], sr_ce[0], sr_sli[0], busy[0], done[0], done_id[0]}), 0);
    repeat (3) drv();
    void'(sb[0].pop_front());
    R_N = 1'b1;
    sb[0].push_back({1'b0, 4'hA});
    sb[0].push_back({1'b1, 4'h4});
    drv();
    req_a[0]  = 1'b1;
    req_b[0]  = 1'b1;
    data_a[0] = 4'hA;
    data_b[0] = 4'h4;
    wait_ack(0, t, id);
    check_val("post_rst_first", id, 0);
    drv();
    req_a[0] = 1'b0;
    wait_ack(0, t, id);
    check_val("post_rst_second", id, 1);
    drv();
    req_b[0] = 1'b0;
    wait_drain(0);

    // DIV=1 instance: back-to-back loads from A
    sb[1].push_back({1'b0, 4'b0110});
    sb[1].push_back({1'b0, 4'b0110});
    drv();
    req_a[1]  = 1'b1;
    data_a[1] = 4'b0110;
    wait_ack(1, t_prev, id);
    wait_ack(1, t, id);
    check_val("div1_gap", t - t_prev, 7);
    drv();
    req_a[1] = 1'b0;
    wait_drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
